// File: rtl/cpu_bus_arbiter.sv
// Arbitrates inst-fetch and load/store onto one SRAM-like bus.
// In-order owner FIFO routes data_ok back to the issuing channel.
module cpu_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_INST,
    GNT_DATA
  } gnt_e;

  gnt_e                 state_q, state_d;
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        starve_q;
  logic [MAX_OUTSTANDING-1:0] own_q;

  logic full, empty;
  logic sel_inst, sel_data;
  logic req_w, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(MAX_OUTSTANDING - 1)) ?
      '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (cnt_q == CW'(MAX_OUTSTANDING));
    empty    = (cnt_q == '0);
    sel_inst = 1'b0;
    sel_data = 1'b0;
    unique case (state_q)
      GNT_INST: sel_inst = 1'b1;
      GNT_DATA: sel_data = 1'b1;
      default: begin
        // full FIFO blocks new grants even if a pop lands now
        if (!full) begin
          if (data_req && !(inst_req &&
              starve_q == SW'(STARVE_LIMIT)))
            sel_data = 1'b1;
          else if (inst_req)
            sel_inst = 1'b1;
        end
      end
    endcase
  end

  assign req_w = (sel_data & data_req) |
                 (sel_inst & inst_req);
  assign push  = req_w & bus_addr_ok;
  assign pop   = bus_data_ok & ~empty;
  assign head  = own_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GNT_IDLE: begin
        if (sel_data && !bus_addr_ok)
          state_d = GNT_DATA;
        else if (sel_inst && !bus_addr_ok)
          state_d = GNT_INST;
      end
      default: begin
        if (bus_addr_ok)
          state_d = GNT_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= GNT_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      own_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        own_q[wr_ptr_q] <= sel_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)
        cnt_q <= cnt_q + 1'b1;
      else if (pop && !push)
        cnt_q <= cnt_q - 1'b1;
      if (!inst_req || (push && sel_inst))
        starve_q <= '0;
      else if (push && sel_data &&
               starve_q != SW'(STARVE_LIMIT))
        starve_q <= starve_q + 1'b1;
    end
  end

  // every output is forced low while reset is held
  always_comb begin
    bus_req      = cpu_rst_n & req_w;
    bus_wr       = 1'b0;
    bus_size     = 2'd0;
    bus_addr     = '0;
    bus_wdata    = '0;
    if (cpu_rst_n && sel_data) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wdata = data_wdata;
    end else if (cpu_rst_n && sel_inst) begin
      bus_size  = 2'd2;
      bus_addr  = inst_addr;
    end
    inst_addr_ok = cpu_rst_n & sel_inst & bus_addr_ok;
    data_addr_ok = cpu_rst_n & sel_data & bus_addr_ok;
    inst_data_ok = cpu_rst_n & pop & ~head;
    data_data_ok = cpu_rst_n & pop & head;
    inst_rdata   = cpu_rst_n ? bus_rdata : '0;
    data_rdata   = cpu_rst_n ? bus_rdata : '0;
  end

  assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Random traffic bench for cpu_bus_arbiter.
// Grant model plus in-order response scoreboard.
module tb_cpu_bus_arbiter;

  localparam int MAXO = 2;
  localparam int LIM  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 1'b0;
  logic        bus_data_ok = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        busy;

  cpu_bus_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT(LIM)
  ) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          owner;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // 0 = none, 1 = inst, 2 = data
  int   lock = 0;
  int   starve = 0;
  bit   ipend = 0;
  bit   dpend = 0;

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_data_ok && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("resp_owner",
                {inst_data_ok, data_data_ok},
                e.owner ? 2'b01 : 2'b10);
          check("resp_rdata",
                e.owner ? data_rdata : inst_rdata,
                e.rdata);
        end else begin
          check("no_data_ok",
                {inst_data_ok, data_data_ok}, 2'b00);
        end
      end
    end
  end

  task automatic cycle(
    input int pi, input int pd,
    input int pa, input int pr
  );
    int own;
    bit acc;
    @(posedge clk);
    #1;
    if (!ipend && $urandom_range(0, 99) < pi) begin
      ipend     = 1;
      inst_addr = $urandom & 32'hffff_fffc;
    end
    if (!dpend && $urandom_range(0, 99) < pd) begin
      dpend      = 1;
      data_wr    = 1'($urandom);
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    inst_req    = ipend;
    data_req    = dpend;
    bus_addr_ok = ($urandom_range(0, 99) < pa);
    bus_data_ok = ($urandom_range(0, 99) < pr);
    bus_rdata   = (exp_q.size() > 0) ?
                  exp_q[0].rdata : $urandom;
    #1;
    if (lock != 0)
      own = lock;
    else if (exp_q.size() == MAXO)
      own = 0;
    else if (dpend && !(ipend && starve == LIM))
      own = 2;
    else if (ipend)
      own = 1;
    else
      own = 0;
    check("bus_req", bus_req, own != 0);
    if (own == 2) begin
      check("bus_addr", bus_addr, data_addr);
      check("bus_ctl", {bus_wr, bus_size, bus_wdata},
            {data_wr, data_size, data_wdata});
    end else if (own == 1) begin
      check("bus_addr", bus_addr, inst_addr);
      check("bus_ctl", {bus_wr, bus_size, bus_wdata},
            {1'b0, 2'd2, 32'd0});
    end
    check("addr_ok", {inst_addr_ok, data_addr_ok},
          {own == 1 && bus_addr_ok,
           own == 2 && bus_addr_ok});
    check("busy", busy, exp_q.size() != 0);
    acc = (own != 0) && bus_addr_ok;
    #5;
    if (!ipend)
      starve = 0;
    else if (acc && own == 1)
      starve = 0;
    else if (acc && own == 2 && starve < LIM)
      starve++;
    if (acc) begin
      exp_q.push_back('{owner: (own == 2),
                        rdata: $urandom});
      if (own == 1) ipend = 0;
      else          dpend = 0;
    end
    lock = (own != 0 && !acc) ? own : 0;
  endtask

  task automatic rst_outs(input string name);
    check({name, "_ctl"},
          {bus_req, bus_wr, bus_size, inst_addr_ok,
           inst_data_ok, data_addr_ok, data_data_ok,
           busy}, '0);
    check({name, "_addr"}, {bus_addr, bus_wdata}, '0);
    check({name, "_rdata"},
          {inst_rdata, data_rdata}, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    inst_req    = 1;
    data_req    = 1;
    inst_addr   = 32'h1fc0_0000;
    data_addr   = 32'h0000_1000;
    data_wr     = 1;
    data_wdata  = 32'hdead_beef;
    data_size   = 2;
    bus_addr_ok = 1;
    bus_data_ok = 1;
    bus_rdata   = 32'h3c08_0001;
    #2;
    rst_n = 0;
    #1;
    rst_outs("rst_enter");
    exp_q.delete();
    lock   = 0;
    starve = 0;
    ipend  = 0;
    dpend  = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_outs("rst_hold");
    inst_req    = 0;
    data_req    = 0;
    bus_addr_ok = 0;
    bus_data_ok = 0;
    rst_n       = 1;
  endtask

  initial begin
    do_reset();
    repeat (3)   cycle(0, 0, 0, 100);
    repeat (300) cycle(50, 50, 60, 40);
    repeat (40)  cycle(100, 100, 100, 100);
    repeat (60)  cycle(100, 100, 30, 20);
    repeat (20)  cycle(90, 90, 100, 0);
    repeat (30)  cycle(50, 50, 60, 40);
    repeat (6)   cycle(80, 80, 100, 0);
    do_reset();
    repeat (4)   cycle(0, 0, 0, 100);
    repeat (300) cycle(40, 60, 70, 50);
    repeat (12)  cycle(0, 0, 100, 100);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares one SRAM-like request/response bus between the instruction-fetch channel and the load/store channel of the CPU core.
- The bus feeds the AXI bridge.
- Grants address phases with data priority and inst anti-starvation, holds a grant until the address is accepted, and tracks outstanding transactions in an in-order owner FIFO.
- Read data and data_ok are routed back through that FIFO to the requester that issued each transaction.

Parameters:
MAX_OUTSTANDING, 2, depth of owner FIFO (power of 2, >=1); max accepted-but-unanswered transactions
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst gets priority

Ports:
cpu_clk_50M  in  1  clock
cpu_rst_n  in  1  reset, asynchronous, active-low
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch physical address
inst_addr_ok  out  1  fetch address accepted this cycle
inst_data_ok  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch data
data_req  in  1  load/store request, held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  32  load/store physical address
data_wdata  in  32  store data
data_addr_ok  out  1  load/store address accepted
data_data_ok  out  1  load data returned or store completed
data_rdata  out  32  load data
bus_req  out  1  downstream request
bus_wr  out  1  downstream write
bus_size  out  2  downstream size
bus_addr  out  32  downstream address
bus_wdata  out  32  downstream write data
bus_addr_ok  in  1  downstream address accepted
bus_data_ok  in  1  downstream response
bus_rdata  in  32  downstream read data
busy  out  1  owner FIFO non-empty

Behaviour:
- Reset (async, cpu_rst_n=0): grant state GNT_IDLE, FIFO empty (rd/wr pointers and count 0), starve counter 0. All outputs are 0 throughout reset. Reset mid-transaction discards all outstanding entries with no data_ok.
- Grant FSM, states GNT_IDLE, GNT_INST, GNT_DATA:
  - GNT_IDLE with FIFO not full: if data_req and !(inst_req && starve==STARVE_LIMIT), select data; else if inst_req, select inst. Selection is combinational, so bus_req can rise in the same cycle as the requester's req.
  - If the selected request is not accepted that cycle (bus_addr_ok=0), move to GNT_DATA or GNT_INST. Stay there, with the muxes locked, until bus_addr_ok, then return to GNT_IDLE. Other requests are not considered while locked.
  - In GNT_IDLE with FIFO full, bus_req=0. This holds even if bus_data_ok pops an entry in the same cycle; the new grant starts the next cycle.
- Muxing:
  - Data owner: bus_wr/size/addr/wdata = data_*.
  - Inst owner: bus_wr=0, bus_size=2, bus_addr=inst_addr, bus_wdata=0.
  - bus_req equals the granted requester's req.
- addr_ok is routed only to the granted requester: <x>_addr_ok = granted==x && bus_addr_ok.
- Push: on bus_req && bus_addr_ok, push owner id (0 = inst, 1 = data) at the FIFO tail.
- Pop: on bus_data_ok with the FIFO non-empty, pop the head and pulse data_ok of the head owner for exactly that cycle. Push and pop in the same cycle leave the count unchanged.
- bus_data_ok with the FIFO empty is ignored: no data_ok to either requester, state unchanged.
- Read data: inst_rdata and data_rdata both equal bus_rdata combinationally. Only the matching data_ok qualifies it.
- Response latency: data_ok is combinational from bus_data_ok (0 added cycles). Grant adds 0 cycles when the arbiter is idle and the FIFO is not full.
- Starve counter, saturating at STARVE_LIMIT:
  - +1 on each accepted data address while inst_req=1.
  - Cleared on accepted inst address, or any cycle inst_req=0.
- Pointers wrap modulo MAX_OUTSTANDING. Count is width clog2(MAX_OUTSTANDING)+1. full = count==MAX_OUTSTANDING.
- busy = count!=0 (registered state, no combinational path).

Test Plan:
- Single fetch: inst_req=1, addr=0x1fc00000; bus_addr_ok the same cycle; bus_data_ok 3 cycles later with rdata=0x3c080001 -> bus_addr=0x1fc00000, bus_size=2, bus_wr=0; inst_addr_ok for 1 cycle; inst_data_ok with inst_rdata=0x3c080001; data_data_ok never set; busy high for 3 cycles.
- Contention: inst_req and data_req both 1, store addr=0x00001000, wdata=0xdeadbeef, size=2 -> data granted first (bus_wr=1); inst granted on the next cycle; responses return data then inst in order.
- Grant hold: inst granted with bus_addr_ok=0 for 4 cycles while data_req rises on cycle 1 -> bus_addr stays inst_addr and data_addr_ok=0 until inst is accepted; data granted the next cycle.
- Starvation: data_req and inst_req held high, bus_addr_ok and bus_data_ok always 1 -> exactly 4 data grants, then 1 inst grant, then the counter restarts.
- FIFO full: MAX_OUTSTANDING=2, two accepted reads, bus_data_ok held low -> bus_req=0 with a third request pending; one bus_data_ok -> bus_req reasserts the next cycle.
- Async reset: cpu_rst_n low mid-clock with 2 outstanding -> all outputs 0 immediately; after release, a late bus_data_ok produces no data_ok and busy stays 0.
